// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and state encoding for the writeback/commit stage
package wb_pkg;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DRAM = 2'd1;
    localparam logic [1:0] WD_PC4  = 2'd2;
    localparam logic [1:0] WD_SEXT = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_commit_if.sv
// rtl/wb_commit_if.sv - execute-to-writeback handshake bundle
interface wb_commit_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_rf_we;
    logic [1:0]  ex_wd_sel;
    logic [4:0]  ex_wR;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_c;
    logic [31:0] ex_pc;
    logic [31:0] ex_sext;

    modport master (
        output ex_valid, ex_rf_we, ex_wd_sel, ex_wR, ex_funct3, ex_alu_c, ex_pc, ex_sext,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_rf_we, ex_wd_sel, ex_wR, ex_funct3, ex_alu_c, ex_pc, ex_sext,
        output ex_ready
    );
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and sign/zero-extends a load result from a word-aligned DRAM word
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[7:0];
        case (addr)
            2'd0: sel_byte = rdata[7:0];
            2'd1: sel_byte = rdata[15:8];
            2'd2: sel_byte = rdata[23:16];
            2'd3: sel_byte = rdata[31:24];
            default: sel_byte = rdata[7:0];
        endcase
        // halfword loads ignore addr[0]; misalignment is not trapped here
        sel_half = addr[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        case (funct3)
            F3_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  result = {24'd0, sel_byte};
            F3_LH:   result = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  result = {16'd0, sel_half};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/wb_commit.sv
// rtl/wb_commit.sv - writeback/commit stage; optional load timeout under WB_TIMEOUT_EN
module wb_commit
    import wb_pkg::*;
`ifdef WB_TIMEOUT_EN
#(
    parameter int TIMEOUT = 255
)
`endif
(
    input  logic          clk,
    input  logic          rst,
    wb_commit_if.slave    ex,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          rf_we,
    output logic [4:0]    wR,
    output logic [31:0]   wD,
    output logic          load_busy,
    output logic [4:0]    load_wR,
    output logic          err
);
    wb_state_t   state, state_nxt;
    logic        accept;
    logic        load_accept;
    logic        lat_we;
    logic [4:0]  lat_wR;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_addr;
    logic [31:0] direct_wd;
    logic [31:0] aligned;

    assign ex.ex_ready  = (state == IDLE);
    assign accept       = ex.ex_valid & ex.ex_ready;
    assign load_accept  = accept & (ex.ex_wd_sel == WD_DRAM);
    assign load_busy    = (state == WAIT_MEM);
    assign load_wR      = load_busy ? lat_wR : 5'd0;

    load_align u_align (
        .rdata  (mem_rdata),
        .addr   (lat_addr),
        .funct3 (lat_f3),
        .result (aligned)
    );

`ifdef WB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wait_cnt;
    logic          expire;

    // expiry on the TIMEOUT-th silent wait cycle; a coincident rvalid wins
    assign expire = (state == WAIT_MEM) && !mem_rvalid && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= expire;
            if (load_accept)
                wait_cnt <= '0;
            else if (state == WAIT_MEM && !mem_rvalid)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (load_accept) state_nxt = WAIT_MEM;
            WAIT_MEM: begin
                if (mem_rvalid) state_nxt = IDLE;
`ifdef WB_TIMEOUT_EN
                else if (expire) state_nxt = IDLE;
`endif
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        direct_wd = ex.ex_alu_c;
        case (ex.ex_wd_sel)
            WD_PC4:  direct_wd = ex.ex_pc + 32'd4;
            WD_SEXT: direct_wd = ex.ex_sext;
            default: direct_wd = ex.ex_alu_c;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            wR       <= 5'd0;
            wD       <= 32'd0;
            lat_we   <= 1'b0;
            lat_wR   <= 5'd0;
            lat_f3   <= 3'd0;
            lat_addr <= 2'd0;
        end else begin
            rf_we <= 1'b0;
            if (load_accept) begin
                lat_we   <= ex.ex_rf_we;
                lat_wR   <= ex.ex_wR;
                lat_f3   <= ex.ex_funct3;
                lat_addr <= ex.ex_alu_c[1:0];
            end else if (accept) begin
                wR    <= ex.ex_wR;
                wD    <= direct_wd;
                rf_we <= ex.ex_rf_we & (ex.ex_wR != 5'd0);
            end else if (state == WAIT_MEM && mem_rvalid) begin
                wR    <= lat_wR;
                wD    <= aligned;
                rf_we <= lat_we & (lat_wR != 5'd0);
            end
        end
    end
endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback/commit stage for the RISC-V core: the writing end of the register-file interface whose read side lives in decode. Accepts completed instructions from execute over a valid/ready handshake, selects the writeback value, waits for multi-cycle DRAM read data on loads, aligns and sign/zero-extends it, and issues one registered write per instruction into the register file. Exposes a pending-load indicator so decode can stall on a load-use hazard.

## Interface
- TIMEOUT, 255: maximum `WAIT_MEM` cycles before abort; only used with `WB_TIMEOUT_EN`.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage can accept this cycle.
- ex_rf_we  in  1  instruction writes the RF.
- ex_wd_sel  in  2  writeback source: 0 ALU, 1 DRAM, 2 PC+4, 3 SEXT.
- ex_wR  in  5  destination register.
- ex_funct3  in  3  load size/sign; used when ex_wd_sel=1.
- ex_alu_c  in  32  ALU result, and load address for loads.
- ex_pc  in  32  instruction PC.
- ex_sext  in  32  immediate.
- mem_rvalid  in  1  DRAM read data valid, single-cycle pulse.
- mem_rdata  in  32  DRAM word, word-aligned.
- rf_we  out  1  register-file write enable.
- wR  out  5  register-file write address.
- wD  out  32  register-file write data.
- load_busy  out  1  a load is waiting for memory.
- load_wR  out  5  destination of the pending load; 0 when idle.
- err  out  1  one-cycle pulse on load timeout (only with `WB_TIMEOUT_EN`).

## Operation
- States: `IDLE`, `WAIT_MEM`. Reset enters `IDLE`.
- `ex_ready` = 1 in `IDLE`, 0 in `WAIT_MEM`. Accept = `ex_valid & ex_ready`.
- `IDLE`, accept, `ex_wd_sel`≠1: register `wR`=`ex_wR`, `rf_we`=`ex_rf_we & (ex_wR≠0)`, and `wD` as follows. ALU gives `ex_alu_c`. PC+4 gives `ex_pc+4`, mod 2^32. SEXT gives `ex_sext`. Stay in `IDLE`.
- `IDLE`, accept, `ex_wd_sel`=1: latch `ex_wR`, `ex_funct3`, `ex_alu_c[1:0]` and `ex_rf_we`. Go to `WAIT_MEM`. `rf_we` is 0 in the next cycle.
- `WAIT_MEM` with `mem_rvalid`: register the aligned data into `wD`, with `rf_we`=latched we & (wR≠0). Return to `IDLE`.
- Load alignment, from the latched addr[1:0] and funct3:
  - 000 LB: byte addr[1:0], sign-extended.
  - 100 LBU: byte addr[1:0], zero-extended.
  - 001 LH: halfword addr[1], sign-extended; addr[0] is ignored.
  - 101 LHU: halfword addr[1], zero-extended.
  - 010 and any other value: full word.
- `mem_rvalid` in `IDLE` is ignored.
- `load_busy` = (state==`WAIT_MEM`). `load_wR` is the latched wR when busy, else 0.
- `rf_we` is a one-cycle pulse per committed instruction. When no commit happens, `rf_we`=0 and `wR`/`wD` hold their last values.
- Reset asserted mid-load: the load is abandoned, no write occurs, and all state returns to reset values.

## Timing
- Reset values: state `IDLE`, `rf_we` 0, `wR` 0, `wD` 0, `load_busy` 0, `load_wR` 0, `err` 0, `ex_ready` 1.
- Non-load: accepted at edge N, `rf_we` high during cycle N+1. Throughput is 1 per cycle.
- Load: accepted at edge N, rvalid sampled at edge M>N, `rf_we` high during cycle M+1. The earliest rvalid that is honoured is the one in the cycle after the accept.
- The RF write happens at the edge that ends the `rf_we` cycle, giving 2-cycle writeback latency from accept for non-loads.

## Configuration
- `WB_TIMEOUT_EN` defined: an 8-bit+ counter clears on entry to `WAIT_MEM` and increments each `WAIT_MEM` cycle without `mem_rvalid`. If it reaches TIMEOUT without rvalid, the stage pulses `err` for one cycle, performs no RF write, and returns to `IDLE`. If rvalid arrives in the same cycle as expiry, rvalid wins and no `err` is raised.
- Undefined: no counter, `err` is tied 0, and the stage waits indefinitely.

## Structure
- Shared package `wb_pkg`:
  - WD_SEL constants (`WD_ALU`, `WD_DRAM`, `WD_PC4`, `WD_SEXT`).
  - FUNCT3 load constants.
  - State encoding.
- Sub-module `load_align`: combinational extractor taking rdata, addr[1:0] and funct3, producing a 32-bit result. It can be verified on its own.

## Test plan
- Reset, then ALU op with wR=5 and alu_c=0x1234 → cycle after accept: `rf_we`=1, `wR`=5, `wD`=0x1234; `rf_we`=0 the cycle after.
- Back-to-back PC+4 commits, pc=0xFFFFFFFC then pc=0x100 → `wD`=0x00000000 then 0x104 on consecutive cycles; `ex_ready` stays 1.
- LB, addr[1:0]=3, rdata=0x80FF_0000, rvalid 3 cycles later → `ex_ready`=0 and `load_busy`=1 with `load_wR` set while waiting; then `wD`=0xFFFFFF80. The same load as LBU gives 0x00000080.
- LHU with addr=2 and rdata=0xBEEF1234 → `wD`=0x0000BEEF. The same with wR=0 → `rf_we` stays 0.
- Reset asserted in `WAIT_MEM`, then a late rvalid arrives → no write, state `IDLE`, all outputs at reset values.
- With `WB_TIMEOUT_EN` and TIMEOUT=4, a load with no rvalid → `err` pulses 1 cycle after 4 wait cycles, no write, `ex_ready` returns to 1.
